// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - state encodings and width helpers shared by the digital lock
package lock_pkg;

  localparam logic [2:0] S_LOCKED    = 3'd0;
  localparam logic [2:0] S_ENTRY     = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_UNLOCKED  = 3'd3;
  localparam logic [2:0] S_NEW_ENTRY = 3'd4;
  localparam logic [2:0] S_CONFIRM   = 3'd5;
  localparam logic [2:0] S_LOCKOUT   = 3'd6;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - one-shot lockout down-counter; done pulses in the last timed cycle
module lock_timer
  import lock_pkg::*;
#(
  parameter int CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  output logic done_o
);

  localparam int TW = cnt_w(CYCLES);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;

  // Loads CYCLES-1 so the done cycle is the last of exactly CYCLES busy cycles.
  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start_i) begin
      cnt_d  = TW'(CYCLES - 1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done_o = busy_q && (cnt_q == '0);

endmodule

// File: rtl/param_digital_lock.sv
// rtl/param_digital_lock.sv - keypad lock FSM with failure lockout and confirmed code change
module param_digital_lock
  import lock_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ent,
  input  logic                                clr,
  input  logic                                change,
  input  logic [DIGIT_W-1:0]                  sw,
  output logic [2:0]                          state_o,
  output logic                                unlocked_o,
  output logic                                lockout_o,
  output logic [$clog2(NUM_DIGITS+1)-1:0]     digit_idx_o,
  output logic [NUM_DIGITS*DIGIT_W-1:0]       entry_o,
  output logic [$clog2(MAX_TRIES+1)-1:0]      fails_o,
  output logic                                err_o,
  output logic                                changed_o
);

  localparam int CW = NUM_DIGITS * DIGIT_W;
  localparam int IW = $clog2(NUM_DIGITS + 1);
  localparam int FW = $clog2(MAX_TRIES + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] entry_q, entry_d;
  logic [CW-1:0] cand_q, cand_d;
  logic [CW-1:0] code_q, code_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fails_q, fails_d;
  logic          err_q, err_d;
  logic          changed_q, changed_d;
  logic          timer_start, timer_done;
  logic          capturing, pass_done;

  assign capturing = (state_q == S_ENTRY) || (state_q == S_NEW_ENTRY) || (state_q == S_CONFIRM);
  assign pass_done = (idx_q == IW'(NUM_DIGITS));

  lock_timer #(.CYCLES(LOCKOUT_CYCLES)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (timer_start),
    .done_o  (timer_done)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    cand_d      = cand_q;
    code_d      = code_q;
    idx_d       = idx_q;
    fails_d     = fails_q;
    err_d       = 1'b0;
    changed_d   = 1'b0;
    timer_start = 1'b0;

    if (capturing) begin
      // clr outranks both a pending pass completion and a same-cycle ent.
      if (clr) begin
        entry_d = '0;
        idx_d   = '0;
      end else if (pass_done) begin
        idx_d = '0;
        if (state_q == S_ENTRY) begin
          state_d = S_CHECK;
        end else if (state_q == S_NEW_ENTRY) begin
          cand_d  = entry_q;
          entry_d = '0;
          state_d = S_CONFIRM;
        end else begin
          if (entry_q == cand_q) begin
            code_d    = cand_q;
            changed_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          entry_d = '0;
          cand_d  = '0;
          state_d = S_UNLOCKED;
        end
      end else if (ent) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (idx_q == IW'(i)) entry_d[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = sw;
        end
        idx_d = idx_q + IW'(1);
      end
    end else begin
      unique case (state_q)
        S_LOCKED: begin
          if (ent) state_d = S_ENTRY;
        end
        S_CHECK: begin
          entry_d = '0;
          if (entry_q == code_q) begin
            fails_d = '0;
            state_d = S_UNLOCKED;
          end else begin
            err_d   = 1'b1;
            fails_d = fails_q + FW'(1);
            if (fails_q == FW'(MAX_TRIES - 1)) begin
              timer_start = 1'b1;
              state_d     = S_LOCKOUT;
            end else begin
              state_d = S_LOCKED;
            end
          end
        end
        S_UNLOCKED: begin
          if (change)   state_d = S_NEW_ENTRY;
          else if (ent) state_d = S_LOCKED;
        end
        S_LOCKOUT: begin
          if (timer_done) begin
            fails_d = '0;
            state_d = S_LOCKED;
          end
        end
        default: state_d = S_LOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_LOCKED;
      entry_q   <= '0;
      cand_q    <= '0;
      code_q    <= DEFAULT_CODE;
      idx_q     <= '0;
      fails_q   <= '0;
      err_q     <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      entry_q   <= entry_d;
      cand_q    <= cand_d;
      code_q    <= code_d;
      idx_q     <= idx_d;
      fails_q   <= fails_d;
      err_q     <= err_d;
      changed_q <= changed_d;
    end
  end

  assign state_o     = state_q;
  assign unlocked_o  = (state_q == S_UNLOCKED) || (state_q == S_NEW_ENTRY) || (state_q == S_CONFIRM);
  assign lockout_o   = (state_q == S_LOCKOUT);
  assign digit_idx_o = idx_q;
  assign entry_o     = entry_q;
  assign fails_o     = fails_q;
  assign err_o       = err_q;
  assign changed_o   = changed_q;

endmodule

// File: tb/tb_param_digital_lock.sv
// tb/tb_param_digital_lock.sv - directed self-checking bench for param_digital_lock (default and 6x3 builds)
module tb_param_digital_lock;

  logic        clk = 1'b0;
  logic        rst_n, ent, clr, change;
  logic [3:0]  sw;
  logic [2:0]  state;
  logic        unlocked, lockout, err, changed;
  logic [2:0]  idx;
  logic [15:0] entry;
  logic [1:0]  fails;

  logic        rst2_n, ent2, clr2, change2;
  logic [2:0]  sw2;
  logic [2:0]  state2;
  logic        unlocked2, lockout2, err2, changed2;
  logic [2:0]  idx2;
  logic [17:0] entry2;
  logic [1:0]  fails2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  param_digital_lock dut (
    .clk(clk), .rst_n(rst_n), .ent(ent), .clr(clr), .change(change), .sw(sw),
    .state_o(state), .unlocked_o(unlocked), .lockout_o(lockout), .digit_idx_o(idx),
    .entry_o(entry), .fails_o(fails), .err_o(err), .changed_o(changed)
  );

  param_digital_lock #(.NUM_DIGITS(6), .DIGIT_W(3)) dut6 (
    .clk(clk), .rst_n(rst2_n), .ent(ent2), .clr(clr2), .change(change2), .sw(sw2),
    .state_o(state2), .unlocked_o(unlocked2), .lockout_o(lockout2), .digit_idx_o(idx2),
    .entry_o(entry2), .fails_o(fails2), .err_o(err2), .changed_o(changed2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press(input logic [3:0] d);
    ent = 1'b1; sw = d;
    tick();
    ent = 1'b0; sw = '0;
  endtask

  task automatic enter4(input logic [15:0] c);
    press(c[15:12]); press(c[11:8]); press(c[7:4]); press(c[3:0]);
  endtask

  // From LOCKED: wake, key the code, then pass through CHECK to the result.
  task automatic attempt(input logic [15:0] c);
    press(4'd0);
    enter4(c);
    tick();
    tick();
  endtask

  task automatic press2(input logic [2:0] d);
    ent2 = 1'b1; sw2 = d;
    tick();
    ent2 = 1'b0; sw2 = '0;
  endtask

  initial begin
    rst_n = 1'b0; ent = 1'b0; clr = 1'b0; change = 1'b0; sw = '0;
    rst2_n = 1'b0; ent2 = 1'b0; clr2 = 1'b0; change2 = 1'b0; sw2 = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    chk("rst_state", 32'(state), 32'd0);
    chk("rst_unlocked", 32'(unlocked), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_entry", 32'(entry), 32'd0);
    chk("rst_fails", 32'(fails), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_changed", 32'(changed), 32'd0);

    // Default code 0000 unlocks, with a single CHECK cycle.
    press(4'd0);
    chk("s1_entry_state", 32'(state), 32'd1);
    chk("s1_wake_idx", 32'(idx), 32'd0);
    enter4(16'h0000);
    chk("s1_idx_full", 32'(idx), 32'd4);
    chk("s1_still_entry", 32'(state), 32'd1);
    tick();
    chk("s1_check_state", 32'(state), 32'd2);
    chk("s1_check_unlocked", 32'(unlocked), 32'd0);
    chk("s1_check_idx", 32'(idx), 32'd0);
    tick();
    chk("s1_unlocked", 32'(unlocked), 32'd1);
    chk("s1_fails", 32'(fails), 32'd0);
    chk("s1_state", 32'(state), 32'd3);

    // Three wrong codes lead to lockout.
    press(4'd0);
    chk("s2_relock", 32'(state), 32'd0);
    for (int t = 1; t <= 3; t++) begin
      press(4'd0);
      enter4(16'h1234);
      chk("s2_entry_buf", 32'(entry), 32'h1234);
      tick();
      chk("s2_check_noerr", 32'(err), 32'd0);
      tick();
      chk("s2_err", 32'(err), 32'd1);
      chk("s2_entry_clr", 32'(entry), 32'd0);
      if (t < 3) begin
        chk("s2_fails", 32'(fails), 32'(t));
        chk("s2_locked", 32'(state), 32'd0);
      end else begin
        chk("s2_lockout", 32'(lockout), 32'd1);
        chk("s2_lockout_state", 32'(state), 32'd6);
      end
    end
    press(4'd0);
    chk("s2_err_pulse_end", 32'(err), 32'd0);
    chk("s2_ent_ignored", 32'(lockout), 32'd1);
    repeat (998) tick();
    chk("s2_lockout_last", 32'(lockout), 32'd1);
    tick();
    chk("s2_lockout_over", 32'(lockout), 32'd0);
    chk("s2_after_state", 32'(state), 32'd0);
    chk("s2_after_fails", 32'(fails), 32'd0);

    // Code change to 9876 with a matching confirm.
    attempt(16'h0000);
    chk("s3_unlocked", 32'(unlocked), 32'd1);
    change = 1'b1; ent = 1'b1;
    tick();
    change = 1'b0; ent = 1'b0;
    chk("s3_new_entry", 32'(state), 32'd4);
    chk("s3_new_unlocked", 32'(unlocked), 32'd1);
    enter4(16'h9876);
    chk("s3_new_buf", 32'(entry), 32'h9876);
    tick();
    chk("s3_confirm", 32'(state), 32'd5);
    chk("s3_confirm_entry", 32'(entry), 32'd0);
    enter4(16'h9876);
    tick();
    chk("s3_changed", 32'(changed), 32'd1);
    chk("s3_no_err", 32'(err), 32'd0);
    chk("s3_back_unlocked", 32'(state), 32'd3);
    tick();
    chk("s3_changed_pulse", 32'(changed), 32'd0);
    press(4'd0);
    attempt(16'h9876);
    chk("s3_new_code_ok", 32'(state), 32'd3);
    press(4'd0);
    attempt(16'h0000);
    chk("s3_old_code_err", 32'(err), 32'd1);
    chk("s3_old_code_fails", 32'(fails), 32'd1);

    // Mismatched confirm keeps the current code.
    attempt(16'h9876);
    chk("s4_unlock_fails0", 32'(fails), 32'd0);
    change = 1'b1;
    tick();
    change = 1'b0;
    enter4(16'h1234);
    tick();
    enter4(16'h1235);
    tick();
    chk("s4_err", 32'(err), 32'd1);
    chk("s4_no_changed", 32'(changed), 32'd0);
    chk("s4_unlocked", 32'(state), 32'd3);
    press(4'd0);
    attempt(16'h1234);
    chk("s4_rejected_code", 32'(state), 32'd0);
    attempt(16'h9876);
    chk("s4_old_code_ok", 32'(state), 32'd3);

    // clr during ENTRY, with ent in the same cycle.
    press(4'd0);
    press(4'd0);
    press(4'd1);
    press(4'd2);
    chk("s5_idx2", 32'(idx), 32'd2);
    chk("s5_entry_partial", 32'(entry), 32'h1200);
    clr = 1'b1; ent = 1'b1; sw = 4'd7;
    tick();
    clr = 1'b0; ent = 1'b0; sw = '0;
    chk("s5_clr_idx", 32'(idx), 32'd0);
    chk("s5_clr_entry", 32'(entry), 32'd0);
    chk("s5_clr_state", 32'(state), 32'd1);
    enter4(16'h9876);
    tick();
    tick();
    chk("s5_unlock", 32'(unlocked), 32'd1);

    // Reset during CONFIRM restores the default code.
    change = 1'b1;
    tick();
    change = 1'b0;
    enter4(16'h5555);
    tick();
    press(4'd5);
    chk("s6_in_confirm", 32'(state), 32'd5);
    rst_n = 1'b0;
    #1;
    chk("s6_rst_state", 32'(state), 32'd0);
    chk("s6_rst_idx", 32'(idx), 32'd0);
    chk("s6_rst_unlocked", 32'(unlocked), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    attempt(16'h9876);
    chk("s6_changed_code_gone", 32'(err), 32'd1);
    attempt(16'h0000);
    chk("s6_default_ok", 32'(state), 32'd3);

    // Six 3-bit digit build: placement, clr, then default code unlocks.
    rst2_n = 1'b1;
    tick();
    chk("w6_rst_state", 32'(state2), 32'd0);
    press2(3'd0);
    press2(3'd5);
    chk("w6_digit0_msb", 32'(entry2), 32'o500000);
    press2(3'd3);
    chk("w6_digit1", 32'(entry2), 32'o530000);
    clr2 = 1'b1;
    tick();
    clr2 = 1'b0;
    chk("w6_clr", 32'(entry2), 32'd0);
    for (int i = 0; i < 6; i++) press2(3'd0);
    chk("w6_idx_full", 32'(idx2), 32'd6);
    tick();
    chk("w6_check", 32'(state2), 32'd2);
    tick();
    chk("w6_unlocked", 32'(unlocked2), 32'd1);
    chk("w6_fails", 32'(fails2), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
